// File: rtl/conv_window_gen.sv
// Streaming 4x4 window generator: three line buffers plus a 4x4 shift window.
// Emits one window per accepted pixel at row>=3, col>=3, with valid/ready output.
module conv_window_gen #(
  parameter int lenOfInput = 8,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [lenOfInput-1:0]      pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [16*lenOfInput-1:0]   win_data,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic                       win_last
);

  localparam int L  = lenOfInput;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [L-1:0]  r_lb0 [IMG_W];
  logic [L-1:0]  r_lb1 [IMG_W];
  logic [L-1:0]  r_lb2 [IMG_W];
  logic [L-1:0]  r_win [4][4];
  logic          r_valid;
  logic          r_last;

  logic          w_acc;
  logic          w_emit;
  logic          w_col_end;
  logic          w_row_end;
  logic [L-1:0]  w_t0;
  logic [L-1:0]  w_t1;
  logic [L-1:0]  w_t2;

  assign pix_ready = !r_valid || win_ready;
  assign w_acc     = pix_valid && pix_ready;
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_emit    = w_acc && (r_row >= RW'(3)) && (r_col >= CW'(3));
  assign w_t0      = r_lb0[r_col];
  assign w_t1      = r_lb1[r_col];
  assign w_t2      = r_lb2[r_col];

  assign win_valid = r_valid;
  assign win_last  = r_last;

  for (genvar gr = 0; gr < 4; gr++) begin : g_r
    for (genvar gc = 0; gc < 4; gc++) begin : g_c
      assign win_data[(gr*4+gc)*L +: L] = r_win[gr][gc];
    end
  end

  // Line buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb0[r_col] <= w_t1;
      r_lb1[r_col] <= w_t2;
      r_lb2[r_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      if (w_acc) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 3; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
        end
        r_win[0][3] <= w_t0;
        r_win[1][3] <= w_t1;
        r_win[2][3] <= w_t2;
        r_win[3][3] <= pix_in;
        if (w_col_end) begin
          r_col <= '0;
          r_row <= w_row_end ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_emit) begin
        r_valid <= 1'b1;
        r_last  <= w_col_end && w_row_end;
      end else if (win_ready) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: frame-image model on a 5x5 instance,
// plus a literal-checked 4x4 instance.
module tb_conv_window_gen;

  localparam int W = 5;
  localparam int H = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [127:0] win_data;
  logic         win_valid;
  logic         win_ready;
  logic         win_last;

  logic [7:0]   p4_in;
  logic         p4_valid;
  logic         p4_ready;
  logic [127:0] w4_data;
  logic         w4_valid;
  logic         w4_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_window_gen #(.lenOfInput(8), .IMG_W(W), .IMG_H(H)) u5 (
    .clk(clk), .rst_n(rst_n),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_data(win_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_last(win_last)
  );

  conv_window_gen #(.lenOfInput(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .pix_in(p4_in), .pix_valid(p4_valid), .pix_ready(p4_ready),
    .win_data(w4_data), .win_valid(w4_valid),
    .win_ready(1'b1), .win_last(w4_last)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int el(input logic [127:0] d, input int r, input int c);
    return int'(d[(r*4+c)*8 +: 8]);
  endfunction

  // Model: the frame image so far, and the queue of windows it implies
  logic [7:0]   img [H][W];
  logic [127:0] expq [$];
  bit           lastq [$];
  logic [127:0] logd [$];
  bit           logl [$];
  int           k = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(win_valid), 0);
      expq.delete();
      lastq.delete();
      k = 0;
    end else begin
      if (win_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_win: got %h want none", win_data);
        end else if (win_data !== expq[0] || win_last !== lastq[0]) begin
          errors++;
          $display("FAIL win: got %h/%0b want %h/%0b",
                   win_data, win_last, expq[0], lastq[0]);
        end
        if (win_ready) begin
          logd.push_back(win_data);
          logl.push_back(win_last);
          if (expq.size() != 0) begin
            void'(expq.pop_front());
            void'(lastq.pop_front());
          end
        end
      end
      chk("pix_ready", int'(pix_ready), int'(!win_valid || win_ready));
      if (pix_valid && pix_ready) begin
        int r;
        int c;
        logic [127:0] w;
        r = k / W;
        c = k % W;
        img[r][c] = pix_in;
        if (r >= 3 && c >= 3) begin
          w = '0;
          for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
              w[(rr*4+cc)*8 +: 8] = img[r-3+rr][c-3+cc];
          expq.push_back(w);
          lastq.push_back(k == W*H-1);
        end
        k = (k + 1) % (W*H);
      end
    end
  end

  int           cnt4 = 0;
  always @(negedge clk) begin
    if (rst_n && w4_valid) cnt4++;
  end

  task automatic send5(input int mode, input int base,
                       input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      int  n;
      bit  a;
      if (gaps) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      pix_in    = (mode == 1) ? ((i % 2 == 0) ? 8'h80 : 8'h7F) : 8'(base + i);
      pix_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        a = pix_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!a && n < 100);
      if (!a) chk("accept_timeout", 0, 1);
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("drained", expq.size(), 0);
  endtask

  task automatic clear_log();
    logd.delete();
    logl.delete();
  endtask

  task automatic stall5();
    int n = 0;
    while (!win_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_seen_win", int'(win_valid), 1);
    win_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_pix_ready", int'(pix_ready), 0);
      chk("stall_valid", int'(win_valid), 1);
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
  endtask

  task automatic check_5x5(input string nm, input int base);
    chk({nm, "_count"}, logd.size(), 4);
    if (logd.size() == 4) begin
      chk({nm, "_d00_0"}, el(logd[0], 0, 0), base + 0);
      chk({nm, "_d00_1"}, el(logd[1], 0, 0), base + 1);
      chk({nm, "_d00_2"}, el(logd[2], 0, 0), base + 5);
      chk({nm, "_d00_3"}, el(logd[3], 0, 0), base + 6);
      chk({nm, "_d33_3"}, el(logd[3], 3, 3), base + 24);
      chk({nm, "_last"}, int'({logl[0], logl[1], logl[2], logl[3]}), 1);
    end
  endtask

  initial begin
    int nl;
    rst_n     = 1'b0;
    pix_in    = '0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    p4_in     = '0;
    p4_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_win_valid", int'(win_valid), 0);
    chk("rst_win_last", int'(win_last), 0);
    chk("rst_win_data", int'(win_data == '0), 1);
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk("rst4_pix_ready", int'(p4_ready), 1);
    @(posedge clk);
    #1;

    // 4x4 frame: a single window, one cycle after pixel 16
    for (int i = 1; i <= 16; i++) begin
      p4_in    = 8'(i);
      p4_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    p4_valid = 1'b0;
    @(negedge clk);
    chk("t4_valid", int'(w4_valid), 1);
    chk("t4_d00", el(w4_data, 0, 0), 1);
    chk("t4_d03", el(w4_data, 0, 3), 4);
    chk("t4_d30", el(w4_data, 3, 0), 13);
    chk("t4_d33", el(w4_data, 3, 3), 16);
    chk("t4_last", int'(w4_last), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_count", cnt4, 1);

    clear_log();
    send5(0, 0, 1'b0, 25);
    drain();
    check_5x5("basic", 0);

    clear_log();
    fork
      send5(0, 0, 1'b0, 25);
      stall5();
    join
    drain();
    check_5x5("stall", 0);

    clear_log();
    send5(1, 0, 1'b0, 25);
    drain();
    chk("sgn_count", logd.size(), 4);
    if (logd.size() == 4) begin
      chk("sgn_d00", el(logd[0], 0, 0), 'h80);
      chk("sgn_d01", el(logd[0], 0, 1), 'h7F);
      chk("sgn_d32", el(logd[0], 3, 2), 'h7F);
      chk("sgn_d33", el(logd[0], 3, 3), 'h80);
    end

    send5(0, 0, 1'b0, 10);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    send5(0, 50, 1'b0, 25);
    drain();
    check_5x5("rstmid", 50);

    clear_log();
    send5(0, 0, 1'b1, 25);
    send5(0, 30, 1'b1, 25);
    drain();
    chk("two_count", logd.size(), 8);
    if (logd.size() == 8) begin
      nl = 0;
      foreach (logl[i]) nl += int'(logl[i]);
      chk("two_lasts", nl, 2);
      chk("two_f1_d33", el(logd[3], 3, 3), 24);
      chk("two_f2_d00", el(logd[4], 0, 0), 30);
      chk("two_f2_d33", el(logd[7], 3, 3), 54);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
